// File: rtl/mult_tile_seq.sv
// Operand sequencer for the 2x2-tile multiplier mult_M: walks the 9 tiles of a 5x5 product,
// feeding lin/col and assembling mat_c plus a sticky overflow flag under start/busy/done.
module mult_tile_seq #(
  parameter int unsigned N  = 5,
  parameter int unsigned DW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N*N*DW-1:0]   mat_a,
  input  logic [N*N*DW-1:0]   mat_b,
  output logic [2*N*DW-1:0]   lin,
  output logic [2*N*DW-1:0]   col,
  input  logic [4*DW-1:0]     n_out,
  input  logic                ovf,
  output logic                busy,
  output logic                done,
  output logic [N*N*DW-1:0]   mat_c,
  output logic                ovf_out
);

  localparam int unsigned MW = N * N * DW;
  localparam int unsigned VW = 2 * N * DW;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      tile_q, tile_d;
  logic [MW-1:0]   a_q, a_d, b_q, b_d, mat_c_q, mat_c_d;
  logic [VW-1:0]   lin_q, lin_d, col_q, col_d;
  logic            busy_q, busy_d, done_q, done_d, ovf_out_q, ovf_out_d;

  // Rows 2tr and 2tr+1 of m; row index N is padding and stays zero.
  function automatic logic [VW-1:0] tile_lin(input logic [MW-1:0] m, input int unsigned t);
    logic [VW-1:0] v;
    int unsigned   r;
    v = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      r = 2 * (t / 3) + i;
      if (r < N) begin
        for (int unsigned k = 0; k < N; k++) begin
          v[VW-1-N*DW*i-DW*k -: DW] = m[MW-1-DW*(N*r+k) -: DW];
        end
      end
    end
    return v;
  endfunction

  // Columns 2tc and 2tc+1 of m; column index N is padding and stays zero.
  function automatic logic [VW-1:0] tile_col(input logic [MW-1:0] m, input int unsigned t);
    logic [VW-1:0] v;
    int unsigned   c;
    v = '0;
    for (int unsigned j = 0; j < 2; j++) begin
      c = 2 * (t % 3) + j;
      if (c < N) begin
        for (int unsigned k = 0; k < N; k++) begin
          v[VW-1-N*DW*j-DW*k -: DW] = m[MW-1-DW*(N*k+c) -: DW];
        end
      end
    end
    return v;
  endfunction

  // Stores the in-range bytes of a 2x2 result tile verbatim; padding bytes are dropped.
  function automatic logic [MW-1:0] tile_store(input logic [MW-1:0] c_in,
                                               input logic [4*DW-1:0] nv,
                                               input int unsigned t);
    logic [MW-1:0] v;
    int unsigned   r, c;
    v = c_in;
    for (int unsigned i = 0; i < 2; i++) begin
      for (int unsigned j = 0; j < 2; j++) begin
        r = 2 * (t / 3) + i;
        c = 2 * (t % 3) + j;
        if (r < N && c < N) begin
          v[MW-1-DW*(N*r+c) -: DW] = nv[4*DW-1-DW*(2*i+j) -: DW];
        end
      end
    end
    return v;
  endfunction

  always_comb begin
    state_d   = state_q;
    tile_d    = tile_q;
    a_d       = a_q;
    b_d       = b_q;
    lin_d     = lin_q;
    col_d     = col_q;
    mat_c_d   = mat_c_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_out_d = ovf_out_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d       = mat_a;
          b_d       = mat_b;
          lin_d     = tile_lin(mat_a, 0);
          col_d     = tile_col(mat_b, 0);
          mat_c_d   = '0;
          ovf_out_d = 1'b0;
          busy_d    = 1'b1;
          tile_d    = 4'd0;
          state_d   = StRun;
        end
      end
      StRun: begin
        mat_c_d   = tile_store(mat_c_q, n_out, 32'(tile_q));
        ovf_out_d = ovf_out_q | ovf;
        if (tile_q == 4'd8) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          tile_d = tile_q + 4'd1;
          lin_d  = tile_lin(a_q, 32'(tile_q) + 32'd1);
          col_d  = tile_col(b_q, 32'(tile_q) + 32'd1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tile_q    <= 4'd0;
      a_q       <= '0;
      b_q       <= '0;
      lin_q     <= '0;
      col_q     <= '0;
      mat_c_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tile_q    <= tile_d;
      a_q       <= a_d;
      b_q       <= b_d;
      lin_q     <= lin_d;
      col_q     <= col_d;
      mat_c_q   <= mat_c_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign lin     = lin_q;
  assign col     = col_q;
  assign mat_c   = mat_c_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf_out = ovf_out_q;

endmodule

// File: tb/tb_mult_tile_seq.sv
// Bench for mult_tile_seq: behavioural mult_M on lin/col, full-matrix golden results queued
// at each start and compared when done pulses.
module tb_mult_tile_seq;

  logic         clk = 1'b0;
  logic         rst, start, ovf, busy, done, ovf_out;
  logic [199:0] mat_a, mat_b, mat_c;
  logic [79:0]  lin, col;
  logic [31:0]  n_out;
  int           mm_s;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [199:0] c;
    logic         o;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mult_tile_seq #(.N(5), .DW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mat_a   (mat_a),
    .mat_b   (mat_b),
    .lin     (lin),
    .col     (col),
    .n_out   (n_out),
    .ovf     (ovf),
    .busy    (busy),
    .done    (done),
    .mat_c   (mat_c),
    .ovf_out (ovf_out)
  );

  // Combinational 2x2 tile multiplier standing in for mult_M.
  always_comb begin
    n_out = '0;
    ovf   = 1'b0;
    mm_s  = 0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        mm_s = 0;
        for (int k = 0; k < 5; k++) begin
          mm_s = mm_s + int'($signed(lin[79-40*i-8*k -: 8])) * int'($signed(col[79-40*j-8*k -: 8]));
        end
        n_out[31-8*(2*i+j) -: 8] = mm_s[7:0];
        if (mm_s > 127 || mm_s < -128) ovf = 1'b1;
      end
    end
  end

  function automatic logic signed [7:0] el(input logic [199:0] m, input int r, input int k);
    return m[199-8*(5*r+k) -: 8];
  endfunction

  function automatic void golden(input logic [199:0] a, input logic [199:0] b,
                                 output logic [199:0] c, output logic o);
    int s;
    c = '0;
    o = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int cc = 0; cc < 5; cc++) begin
        s = 0;
        for (int k = 0; k < 5; k++) s = s + int'(el(a, r, k)) * int'(el(b, k, cc));
        c[199-8*(5*r+cc) -: 8] = s[7:0];
        if (s > 127 || s < -128) o = 1'b1;
      end
    end
  endfunction

  function automatic logic [199:0] m_seq();
    logic [199:0] m;
    for (int i = 0; i < 25; i++) m[199-8*i -: 8] = 8'(i + 1);
    return m;
  endfunction

  function automatic logic [199:0] m_ident();
    logic [199:0] m;
    m = '0;
    for (int i = 0; i < 5; i++) m[199-8*(6*i) -: 8] = 8'd1;
    return m;
  endfunction

  function automatic logic [199:0] m_fill(input logic [7:0] v);
    logic [199:0] m;
    for (int i = 0; i < 25; i++) m[199-8*i -: 8] = v;
    return m;
  endfunction

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: plain run, 1: operand packing probes, 2: extra start pulse mid-run
  task automatic run(input logic [199:0] a, input logic [199:0] b, input string name,
                     input int mode);
    exp_t e;
    int   busy_cyc, lat;
    bit   done_seen;
    golden(a, b, e.c, e.o);
    sb.push_back(e);
    mat_a     = a;
    mat_b     = b;
    start     = 1'b1;
    busy_cyc  = 0;
    lat       = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      tick();
      if (i == 0) begin
        start = 1'b0;
        mat_a = ~a;
        mat_b = ~b;
      end
      if (mode == 2 && i == 3) start = 1'b1;
      if (mode == 2 && i == 4) start = 1'b0;
      if (mode == 1 && i == 4) begin
        check({name, "_lin_t4"}, 200'(lin), 200'(80'h0B0C0D0E0F_1011121314));
        check({name, "_col_t4"}, 200'(col), 200'(80'h03080D1217_04090E1318));
      end
      if (mode == 1 && i == 8) begin
        check({name, "_lin_t8"}, 200'(lin), 200'(80'h1516171819_0000000000));
        check({name, "_col_t8"}, 200'(col), 200'(80'h050A0F1419_0000000000));
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_seen = 1'b1;
        lat       = i;
      end
    end
    check({name, "_done_seen"}, 200'(done_seen), 200'(1));
    check({name, "_busy_cycles"}, 200'(busy_cyc), 200'(9));
    check({name, "_latency"}, 200'(lat), 200'(9));
    e = sb.pop_front();
    check({name, "_mat_c"}, mat_c, e.c);
    check({name, "_ovf_out"}, 200'(ovf_out), 200'(e.o));
    tick();
    check({name, "_done_single"}, 200'(done), 200'(0));
    check({name, "_busy_after"}, 200'(busy), 200'(0));
    check({name, "_mat_c_held"}, mat_c, e.c);
  endtask

  initial begin
    int done_cnt;
    rst   = 1'b1;
    start = 1'b1;
    mat_a = m_seq();
    mat_b = m_seq();
    tick();
    tick();
    check("rst_lin", 200'(lin), '0);
    check("rst_col", 200'(col), '0);
    check("rst_mat_c", mat_c, '0);
    check("rst_busy", 200'(busy), '0);
    check("rst_done", 200'(done), '0);
    check("rst_ovf_out", 200'(ovf_out), '0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("rst_no_run", 200'(busy), '0);

    run(m_ident(), m_seq(), "ident", 0);
    check("ident_is_b", mat_c, m_seq());
    run(m_seq(), m_seq(), "pack", 1);
    run(m_fill(8'd10), m_fill(8'd10), "ovf", 0);
    check("ovf_set", 200'(ovf_out), 200'(1));
    run(m_ident(), m_seq(), "ovf_clear", 0);
    check("ovf_cleared", 200'(ovf_out), 200'(0));
    run(m_fill(8'hFF), m_ident(), "signed", 0);
    check("signed_all_ff", mat_c, m_fill(8'hFF));
    run(m_seq(), m_ident(), "restart", 2);

    // Abort: reset lands in the 4th RUN cycle.
    mat_a = m_seq();
    mat_b = m_seq();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 200'(busy), '0);
    check("abort_mat_c", mat_c, '0);
    check("abort_lin", 200'(lin), '0);
    check("abort_ovf_out", 200'(ovf_out), '0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort_no_done", 200'(done_cnt), '0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_tile_seq.md
Name: mult_tile_seq

Overview:
- Operand sequencer directly upstream of the 2x2-tile matrix multiplier `mult_M`.
- Latches two 5x5 signed 8-bit matrices A and B, then walks the 9 output tiles of C = A x B.
- For each tile it drives mult_M's `lin`/`col` vectors and captures its `n_out`/`ovf`.
- Assembles the 200-bit result C with a sticky overflow flag, under a start/busy/done handshake.

Parameters:
- N, 5: matrix dimension (fixed at 5; the widths below assume it).
- DW, 8: element width in bits, two's complement.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only while busy=0.
- mat_a  input  200  A, row-major, element (r,k) at bits [199-8*(5r+k) -: 8].
- mat_b  input  200  B, same packing as A.
- lin  output  80  to mult_M: {A(r0,0..4), A(r1,0..4)}, MSB-first.
- col  output  80  to mult_M: {B(0..4,c0), B(0..4,c1)}, MSB-first.
- n_out  input  32  from mult_M: {C(r0,c0), C(r0,c1), C(r1,c0), C(r1,c1)}, MSB-first.
- ovf  input  1  from mult_M: overflow flag for the current tile.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when mat_c is complete.
- mat_c  output  200  result C, same packing as A.
- ovf_out  output  1  sticky OR of ovf over all 9 tiles of the last run.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs lin, col, mat_c, busy, done and ovf_out all go to 0.
  - State goes to IDLE; the tile counter goes to 0.
  - Reset mid-operation aborts the run; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1 (edge E0): latch mat_a/mat_b internally.
  - Load lin/col for tile 0; clear mat_c and ovf_out; busy<=1; go to RUN.
- Tile order and indexing:
  - Tile t=0..8; tr=t/3, tc=t%3.
  - Rows r0=2tr, r1=2tr+1; cols c0=2tc, c1=2tc+1.
  - Index 5 is padding: its lin/col bytes are driven as 0.
- mult_M is combinational: n_out/ovf are valid in the same cycle lin/col are stable.
- RUN, one tile per cycle:
  - At edge E(t+1), t=0..8: capture n_out of tile t into mat_c.
  - Write only in-range entries (row<5 and col<5); discard padding bytes.
  - ovf_out <= ovf_out | ovf.
  - In the same edge, load lin/col for tile t+1 (for t<8).
- End of run:
  - At E9 (tile 8 captured): busy<=0, done<=1, go to DONE.
  - lin/col hold tile 8 values until the next start.
- DONE: lasts one cycle; done<=0; return to IDLE.
- Latency:
  - done is high in the cycle after E9, i.e. 9 cycles after the start edge.
  - mat_c and ovf_out are valid from E9 and held until the next accepted start.
- start while busy=1 or in DONE is ignored.
- start held high in IDLE starts a new run each time IDLE is reached.
- mat_a/mat_b changes after E0 have no effect on the current run.
- No arithmetic is done here; n_out bytes are stored verbatim (no sign extension or saturation).
- rst has priority over start in the same cycle.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 -> lin=col=mat_c=0, busy=done=ovf_out=0; no run starts.
- Identity check:
  - Stimulus: A=identity, B=elements 1..25, bench golden 2x2 dot-product model on lin/col (wrap mod 256, ovf if any sum outside [-128,127]).
  - Required: mat_c=B, ovf_out=0.
  - Required: busy high for exactly 9 cycles; done pulses once, 9 cycles after the start edge.
- Operand packing, A=B=elements 1..25:
  - During tile 4: lin bytes = 11..20; col = {3,8,13,18,23,4,9,14,19,24}.
  - During tile 8: lin = {21..25, 0,0,0,0,0}; col = {5,10,15,20,25, 0,0,0,0,0}.
- Overflow: A all 10, B all 10 (dot product 500) -> ovf_out=1 after done.
  - A following run with A=identity clears ovf_out to 0.
- Signed values: A=-1 everywhere, B=identity -> mat_c all 0xFF, ovf_out=0.
- Handshake and abort:
  - Pulse start again 3 cycles into a run -> ignored; a single done, correct mat_c.
  - Assert rst at the 4th RUN cycle -> busy=0, mat_c=0, no done pulse.
